// File: rtl/snoop_bus_arbiter.sv
// Round-robin arbiter and transaction sequencer for the 3-cache snooping bus.
// Sequences each transaction through emitter, optional snoop and completion phases.
module snoop_bus_arbiter #(
    parameter int         SNOOP_TIMEOUT = 4,
    parameter logic [2:0] MSG_INV       = 3'b011
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [14:0] bus_in,
    output logic [2:0]  wr_bus,
    output logic [2:0]  gnt_done,
    output logic        snoop_hit,
    output logic [7:0]  snoop_data,
    output logic        busy
);
    localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SNOOP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, GRANT, SNOOP, DONE} state_t;

    typedef struct packed {
        logic [2:0] tag;
        logic [2:0] msg;
        logic       vld;
        logic [7:0] data;
    } bus_t;

    state_t        state;
    bus_t          bus;
    logic [1:0]    owner;
    logic [1:0]    rr_ptr;
    logic [1:0]    pick;
    logic [CW-1:0] cnt;
    logic [2:0]    creq;
    logic          unused_tag;

    function automatic logic [2:0] onehot(input logic [1:0] c);
        onehot = 3'b100 >> c;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] c);
        inc3 = (c == 2'd2) ? 2'd0 : c + 2'd1;
    endfunction

    assign bus        = bus_t'(bus_in);
    assign unused_tag = ^bus.tag;
    // creq[i] is cache i's request; the external bit order is reversed
    assign creq       = {req[0], req[1], req[2]};

    always_comb begin
        logic [1:0] c;
        logic       found;
        pick  = rr_ptr;
        found = 1'b0;
        c     = rr_ptr;
        for (int k = 0; k < 3; k++) begin
            if (creq[c] && !found) begin
                pick  = c;
                found = 1'b1;
            end
            c = inc3(c);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_bus     <= 3'b000;
            gnt_done   <= 3'b000;
            snoop_hit  <= 1'b0;
            snoop_data <= 8'h00;
            busy       <= 1'b0;
            rr_ptr     <= 2'd0;
            owner      <= 2'd0;
            cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    gnt_done <= 3'b000;
                    wr_bus   <= 3'b000;
                    if (|req) begin
                        owner  <= pick;
                        wr_bus <= onehot(pick);
                        busy   <= 1'b1;
                        state  <= GRANT;
                    end
                end
                GRANT: begin
                    wr_bus    <= 3'b000;
                    snoop_hit <= 1'b0;
                    if (bus.msg == MSG_INV) begin
                        gnt_done <= onehot(owner);
                        state    <= DONE;
                    end else begin
                        cnt   <= '0;
                        state <= SNOOP;
                    end
                end
                SNOOP: begin
                    // first valid wins; a valid in the last timeout cycle still counts
                    if (bus.vld) begin
                        snoop_hit  <= 1'b1;
                        snoop_data <= bus.data;
                        gnt_done   <= onehot(owner);
                        state      <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        snoop_hit <= 1'b0;
                        gnt_done  <= onehot(owner);
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    gnt_done <= 3'b000;
                    wr_bus   <= 3'b000;
                    rr_ptr   <= inc3(owner);
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Bench for snoop_bus_arbiter: timestamp model checked every cycle plus directed literal checks.
module tb_snoop_bus_arbiter;
    localparam int         TO  = 4;
    localparam logic [2:0] INV = 3'b011;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [14:0] bus_in = 15'h0;
    logic [2:0]  wr_bus, gnt_done;
    logic        snoop_hit, busy;
    logic [7:0]  snoop_data;

    int n_chk  = 0;
    int n_fail = 0;

    snoop_bus_arbiter #(.SNOOP_TIMEOUT(TO), .MSG_INV(INV)) dut (
        .clock(clock), .reset(reset), .req(req), .bus_in(bus_in),
        .wr_bus(wr_bus), .gnt_done(gnt_done), .snoop_hit(snoop_hit),
        .snoop_data(snoop_data), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b, expected %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03b, expected %03b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] oh(input int i);
        return 3'b100 >> i;
    endfunction

    function automatic logic [14:0] mk(input logic [2:0] msg, input logic v, input logic [7:0] d);
        return {3'b101, msg, v, d};
    endfunction

    // Model: each transaction is a grant edge plus a completion edge found once the
    // bus reveals it; outputs follow from where the current edge sits in that interval.
    int         cyc = 0;
    int         m_g = 0, m_done = -1, m_owner = 0, m_rr = 0;
    bit         m_act = 1'b0;
    logic [2:0] e_wr = 3'b000, e_done = 3'b000;
    logic       e_hit = 1'b0, e_busy = 1'b0;
    logic [7:0] e_data = 8'h00;

    initial forever begin
        @(posedge clock);
        cyc++;
        if (reset) begin
            m_act = 1'b0; m_rr = 0; m_done = -1;
            e_wr = 3'b000; e_done = 3'b000; e_hit = 1'b0; e_data = 8'h00; e_busy = 1'b0;
        end else begin
            if (m_act) begin
                if (cyc == m_g) begin
                    e_hit = 1'b0;
                    if (bus_in[11:9] == INV) m_done = cyc + 1;
                end else if (cyc > m_g && m_done < 0) begin
                    if (bus_in[8]) begin
                        m_done = cyc + 1; e_hit = 1'b1; e_data = bus_in[7:0];
                    end else if (cyc - m_g == TO) begin
                        m_done = cyc + 1;
                    end
                end else if (cyc == m_done) begin
                    m_act = 1'b0;
                    m_rr  = (m_owner + 1) % 3;
                end
            end else if (req != 3'b000) begin
                bit found;
                found = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (m_rr + k) % 3;
                    if (!found && req[2-i]) begin
                        m_owner = i; found = 1'b1;
                    end
                end
                m_act = 1'b1; m_g = cyc + 1; m_done = -1;
            end
            e_wr   = (m_act && cyc + 1 == m_g)    ? oh(m_owner) : 3'b000;
            e_done = (m_act && cyc + 1 == m_done) ? oh(m_owner) : 3'b000;
            e_busy = m_act;
        end
    end

    initial forever begin
        @(posedge clock);
        #2;
        chk3("wr_bus", wr_bus, e_wr);
        chk3("gnt_done", gnt_done, e_done);
        chk1("snoop_hit", snoop_hit, e_hit);
        chk8("snoop_data", snoop_data, e_data);
        chk1("busy", busy, e_busy);
        chk1("wr_bus_onehot0", $onehot0(wr_bus), 1'b1);
        chk1("done_wr_overlap", (|gnt_done) && (|wr_bus), 1'b0);
    end

    task automatic nx();
        @(negedge clock);
    endtask

    task automatic wait_done(output logic [2:0] got);
        int n;
        n = 0;
        do begin
            nx();
            n++;
        end while (gnt_done == 3'b000 && n < 20);
        got = gnt_done;
        if (gnt_done == 3'b000) $display("FAIL wait_done: no gnt_done within 20 cycles");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] got;
        nx(); nx();
        chk3("rst_wr_bus", wr_bus, 3'b000);
        chk3("rst_gnt_done", gnt_done, 3'b000);
        chk1("rst_snoop_hit", snoop_hit, 1'b0);
        chk8("rst_snoop_data", snoop_data, 8'h00);
        chk1("rst_busy", busy, 1'b0);
        reset = 1'b0;
        nx();

        // invalidate from cache 0
        req = 3'b100; bus_in = mk(INV, 1'b0, 8'h00);
        nx(); chk3("t1_wr", wr_bus, 3'b100); chk1("t1_busy", busy, 1'b1);
        nx(); chk3("t1_done", gnt_done, 3'b100); chk3("t1_wr0", wr_bus, 3'b000);
        chk1("t1_hit", snoop_hit, 1'b0);
        req = 3'b000;
        nx(); chk1("t1_idle", busy, 1'b0); chk3("t1_done0", gnt_done, 3'b000);

        // cache 1 miss, responder valid in first snoop cycle
        req = 3'b010; bus_in = mk(3'b001, 1'b0, 8'h00);
        nx(); chk3("t2_wr", wr_bus, 3'b010);
        bus_in = mk(3'b001, 1'b1, 8'hA5);
        nx(); chk3("t2_snoop_wr", wr_bus, 3'b000); chk3("t2_nodone", gnt_done, 3'b000);
        nx(); chk3("t2_done", gnt_done, 3'b010); chk1("t2_hit", snoop_hit, 1'b1);
        chk8("t2_data", snoop_data, 8'hA5);
        req = 3'b000; bus_in = mk(3'b001, 1'b1, 8'h5A);
        nx(); chk8("t2_data_hold", snoop_data, 8'hA5); chk1("t2_idle", busy, 1'b0);
        bus_in = mk(3'b001, 1'b0, 8'h00);

        // cache 2 miss, full timeout
        req = 3'b001;
        nx(); chk3("t3_wr", wr_bus, 3'b001); chk1("t3_hit_held", snoop_hit, 1'b1);
        chk8("t3_data_held", snoop_data, 8'hA5);
        nx(); chk1("t3_hit_clr", snoop_hit, 1'b0);
        nx(); nx(); nx(); chk3("t3_last_snoop", gnt_done, 3'b000);
        nx(); chk3("t3_done", gnt_done, 3'b001); chk1("t3_hit", snoop_hit, 1'b0);
        req = 3'b000;
        nx();

        // all three requesting, two rounds; rr order must wrap 0,1,2,0,1,2
        bus_in = mk(INV, 1'b0, 8'h00);
        for (int r = 0; r < 2; r++) begin
            req = 3'b111;
            for (int k = 0; k < 3; k++) begin
                wait_done(got);
                chk3($sformatf("t4_order_r%0d_k%0d", r, k), got, oh(k));
                req = req & ~got;
            end
        end
        nx();

        // reset in the middle of a snoop phase
        req = 3'b100; bus_in = mk(3'b001, 1'b0, 8'h00);
        nx(); chk3("t5_wr", wr_bus, 3'b100);
        nx(); chk1("t5_busy", busy, 1'b1);
        #1 reset = 1'b1;
        #1 chk3("t5_async_wr", wr_bus, 3'b000); chk1("t5_async_busy", busy, 1'b0);
        chk3("t5_async_done", gnt_done, 3'b000);
        req = 3'b000;
        nx(); nx();
        reset = 1'b0;
        nx(); chk3("t5_no_done", gnt_done, 3'b000); chk1("t5_idle", busy, 1'b0);
        req = 3'b100; bus_in = mk(INV, 1'b0, 8'h00);
        nx(); chk3("t5_regrant", wr_bus, 3'b100);
        nx(); chk3("t5_redone", gnt_done, 3'b100);
        req = 3'b000;
        nx();

        // req dropped during GRANT, valid in final timeout cycle
        req = 3'b010; bus_in = mk(3'b001, 1'b0, 8'h00);
        nx(); chk3("t6_wr", wr_bus, 3'b010);
        req = 3'b000;
        nx(); nx(); nx(); nx(); chk3("t6_nodone", gnt_done, 3'b000);
        bus_in = mk(3'b001, 1'b1, 8'h3C);
        nx(); chk3("t6_done", gnt_done, 3'b010); chk1("t6_hit", snoop_hit, 1'b1);
        chk8("t6_data", snoop_data, 8'h3C);
        bus_in = 15'h0;
        nx(); nx();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
